mem_burst_model: RTL and testbench
==================================

MEM_BURST_MODEL -- requirements
Module: mem_burst_model

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32: byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: beat width; a multiple of 8 and a power of 2.
REQ-003 SHALL have parameter DEPTH, default 1024: words in array; power of 2.
REQ-004 SHALL have parameter DELAY, default 4: access latency in cycles; legal range 1..255.
REQ-005 SHALL have parameter BURST_LEN, default 4: read beats per request; power of 2, at most DEPTH.
REQ-006 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-007 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port req_valid, input, 1: request present.
REQ-009 SHALL have port req_ready, output, 1: request accepted when req_valid and req_ready are both high at a rising edge.
REQ-010 SHALL have port req_address, input, ADDRESS_WIDTH: byte address.
REQ-011 SHALL have port req_wen, input, 1: 1 = single-beat write, 0 = burst read.
REQ-012 SHALL have port req_be, input, DATA_WIDTH/8: write byte enables.
REQ-013 SHALL have port req_data, input, DATA_WIDTH: write data.
REQ-014 SHALL have port resp_valid, output, 1: response beat present.
REQ-015 SHALL have port resp_ready, input, 1: beat consumed when resp_valid and resp_ready are both high at a rising edge.
REQ-016 SHALL have port resp_data, output, DATA_WIDTH: read data; 0 for a write response.
REQ-017 SHALL have port resp_last, output, 1: marks the final beat of a response.

Function
REQ-018 SHALL decode word index as req_address[ADDRESS_WIDTH-1 : log2(DATA_WIDTH/8)] modulo DEPTH; high bits beyond DEPTH wrap.
REQ-019 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; req_ready=1 only in IDLE.
REQ-020 SHALL on acceptance latch address, wen, be, data, load latency counter with DELAY and enter WAIT.
REQ-021 SHALL decrement the counter each WAIT cycle and enter RESP when it reaches 1, so the first resp_valid is high exactly DELAY cycles after the accepting edge.
REQ-022 SHALL, for a read, start the burst at the word index aligned down to a BURST_LEN boundary and return BURST_LEN consecutive words, asserting resp_last on the final one.
REQ-023 SHALL, for a write, update only the bytes with req_be set, on the WAIT->RESP edge, then return one beat with resp_data=0 and resp_last=1.
REQ-024 SHALL hold resp_valid, resp_data and resp_last stable while resp_valid=1 and resp_ready=0.
REQ-025 SHALL advance to the next beat on each handshake and return to IDLE on the handshake of the resp_last beat; req_ready rises the following cycle.
REQ-026 SHALL ignore req_valid outside IDLE; no queuing, exactly one outstanding transaction.
REQ-027 SHALL initialise array word i to i+1 at simulation start; reset SHALL NOT alter array contents.

Reset
REQ-028 SHALL on rst_n low, asynchronously, force state IDLE, counter 0, beat index 0, resp_valid=0, resp_last=0, resp_data=0; req_ready=1 once rst_n is high.
REQ-029 SHALL on reset mid-transaction abandon it with no further beats; a write not yet committed at the WAIT->RESP edge SHALL leave memory unchanged.

Structure
REQ-030 SHALL place the FSM state enum and default parameter constants in shared package mem_pkg.
REQ-031 SHALL instantiate one sub-module, mem_array: a single-port byte-enable RAM with a registered read, holding the storage and its initialisation.

Verification
REQ-032 SHALL cover aligned read: DELAY=4, BURST_LEN=4, read 0x10 with resp_ready=1 -> beats 5,6,7,8, first beat 4 cycles after accept, resp_last on the 4th.
REQ-033 SHALL cover byte-enable write: write 0x08, be=4'b0011, data 0xAABBCCDD, then read 0x00 -> beats 1, 2, 0x0000CCDD, 4.
REQ-034 SHALL cover backpressure: resp_ready low 3 cycles during beat 2 of read 0x00 -> data 2 held stable, no beat lost or duplicated.
REQ-035 SHALL cover busy rejection: second req_valid during WAIT -> req_ready=0; accepted the cycle after the resp_last handshake.
REQ-036 SHALL cover reset mid-burst: rst_n low during beat 2 -> resp_valid=0 at once; next read 0x00 returns 1,2,3,4.
REQ-037 SHALL cover address wrap: DEPTH=1024, read byte address 4*(1024+4) -> beats 5,6,7,8.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants and FSM state type for the burst memory model.
package mem_pkg;

   localparam int unsigned DEF_ADDRESS_WIDTH = 32;
   localparam int unsigned DEF_DATA_WIDTH    = 32;
   localparam int unsigned DEF_DEPTH         = 1024;
   localparam int unsigned DEF_DELAY         = 4;
   localparam int unsigned DEF_BURST_LEN     = 4;

   // Latency counter holds DELAY, which is capped at 255.
   localparam int unsigned CNT_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

endpackage

// File: rtl/mem_array.sv
// Single-port byte-enable RAM with registered read; word i reads as i+1 before it is written.
module mem_array
   import mem_pkg::*;
#(
   parameter  int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter  int unsigned DEPTH      = DEF_DEPTH,
   localparam int unsigned NB         = DATA_WIDTH / 8,
   localparam int unsigned IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en_i,
   input  logic                  we_i,
   input  logic [NB-1:0]         be_i,
   input  logic [IDX_W-1:0]      addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   // Storage is kept XOR-keyed by (index+1): an all-zero array reads back as i+1,
   // and the key is bytewise so partial writes need no read-modify-write.
   logic [DATA_WIDTH-1:0] store_q [DEPTH] = '{default: '0};
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [DATA_WIDTH-1:0] key_c;

   assign key_c = DATA_WIDTH'(addr_i) + DATA_WIDTH'(1);

   always_ff @(posedge clk) begin
      if (en_i && we_i) begin
         for (int unsigned b = 0; b < NB; b++) begin
            if (be_i[b]) begin
               store_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8] ^ key_c[8*b +: 8];
            end
         end
      end
   end

   // A write cycle returns zero on the read port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else if (en_i) begin
         rdata_q <= we_i ? '0 : (store_q[addr_i] ^ key_c);
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_burst_model.sv
// Fixed-latency memory model: single-beat byte-enable writes, aligned BURST_LEN-beat reads.
module mem_burst_model
   import mem_pkg::*;
#(
   parameter int unsigned ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
   parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter int unsigned DEPTH         = DEF_DEPTH,
   parameter int unsigned DELAY         = DEF_DELAY,
   parameter int unsigned BURST_LEN     = DEF_BURST_LEN
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [ADDRESS_WIDTH-1:0] req_address,
   input  logic                     req_wen,
   input  logic [DATA_WIDTH/8-1:0]  req_be,
   input  logic [DATA_WIDTH-1:0]    req_data,
   output logic                     resp_valid,
   input  logic                     resp_ready,
   output logic [DATA_WIDTH-1:0]    resp_data,
   output logic                     resp_last
);

   localparam int unsigned NB     = DATA_WIDTH / 8;
   localparam int unsigned OFF_W  = $clog2(NB);
   localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

   localparam logic [IDX_W-1:0]  ALIGN_MASK = ~IDX_W'(BURST_LEN - 1);
   localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
   localparam logic [CNT_W-1:0]  DELAY_LD   = CNT_W'(DELAY);

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q,   cnt_d;
   logic [BEAT_W-1:0]     beat_q,  beat_d;
   logic [IDX_W-1:0]      idx_q,   idx_d;
   logic                  wen_q,   wen_d;
   logic [NB-1:0]         be_q,    be_d;
   logic [DATA_WIDTH-1:0] data_q,  data_d;
   logic                  ready_q, ready_d;
   logic                  valid_q, valid_d;
   logic                  last_q,  last_d;

   logic                  ram_en;
   logic                  ram_we;
   logic [IDX_W-1:0]      ram_addr;
   logic [DATA_WIDTH-1:0] ram_rdata;
   logic [IDX_W-1:0]      burst_base;
   logic [BEAT_W-1:0]     beat_nxt;

   assign burst_base = idx_q & ALIGN_MASK;
   assign beat_nxt   = beat_q + BEAT_W'(1);

   // Next-state, request capture and RAM port control.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      beat_d   = beat_q;
      idx_d    = idx_q;
      wen_d    = wen_q;
      be_d     = be_q;
      data_d   = data_q;
      ready_d  = ready_q;
      valid_d  = valid_q;
      last_d   = last_q;
      ram_en   = 1'b0;
      ram_we   = 1'b0;
      ram_addr = burst_base | IDX_W'(beat_q);

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               idx_d   = IDX_W'(req_address >> OFF_W);
               wen_d   = req_wen;
               be_d    = req_be;
               data_d  = req_data;
               cnt_d   = DELAY_LD;
               ready_d = 1'b0;
               state_d = ST_WAIT;
            end
         end

         ST_WAIT: begin
            // Final wait cycle: commit the write or fetch the first read beat.
            if (cnt_q == CNT_W'(1)) begin
               ram_en   = 1'b1;
               ram_we   = wen_q;
               ram_addr = wen_q ? idx_q : burst_base;
               cnt_d    = '0;
               beat_d   = '0;
               valid_d  = 1'b1;
               last_d   = wen_q || (BURST_LEN == 1);
               state_d  = ST_RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         ST_RESP: begin
            if (resp_ready) begin
               if (last_q) begin
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  beat_d  = '0;
                  ready_d = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  ram_en   = 1'b1;
                  ram_addr = burst_base | IDX_W'(beat_nxt);
                  beat_d   = beat_nxt;
                  last_d   = (beat_nxt == LAST_BEAT);
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         beat_q  <= '0;
         idx_q   <= '0;
         wen_q   <= 1'b0;
         be_q    <= '0;
         data_q  <= '0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         beat_q  <= beat_d;
         idx_q   <= idx_d;
         wen_q   <= wen_d;
         be_q    <= be_d;
         data_q  <= data_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
         last_q  <= last_d;
      end
   end

   mem_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_mem_array (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (ram_en),
      .we_i    (ram_we),
      .be_i    (be_q),
      .addr_i  (ram_addr),
      .wdata_i (data_q),
      .rdata_o (ram_rdata)
   );

   assign req_ready  = ready_q;
   assign resp_valid = valid_q;
   assign resp_last  = last_q;
   assign resp_data  = ram_rdata;

endmodule

// File: tb/tb_mem_burst_model.sv
// Directed and randomized checks of mem_burst_model against a word-array reference model.
module tb_mem_burst_model;

   localparam int unsigned AW    = 32;
   localparam int unsigned DW    = 32;
   localparam int unsigned NB    = DW / 8;
   localparam int unsigned DEPTH = 1024;
   localparam int unsigned DELAY = 4;
   localparam int unsigned BL    = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [AW-1:0] req_address = '0;
   logic          req_wen = 1'b0;
   logic [NB-1:0] req_be = '0;
   logic [DW-1:0] req_data = '0;
   logic          resp_valid;
   logic          resp_ready = 1'b0;
   logic [DW-1:0] resp_data;
   logic          resp_last;

   int unsigned   checks = 0;
   int unsigned   errors = 0;
   logic [DW-1:0] ref_mem [DEPTH];

   always #5 clk = ~clk;

   mem_burst_model #(
      .ADDRESS_WIDTH (AW),
      .DATA_WIDTH    (DW),
      .DEPTH         (DEPTH),
      .DELAY         (DELAY),
      .BURST_LEN     (BL)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_address (req_address),
      .req_wen     (req_wen),
      .req_be      (req_be),
      .req_data    (req_data),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_data   (resp_data),
      .resp_last   (resp_last)
   );

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_resp_valid", DW'(resp_valid), 0);
      chk("rst_resp_last", DW'(resp_last), 0);
      chk("rst_resp_data", resp_data, 0);
      #2;
      rst_n = 1'b1;
      resp_ready = 1'b0;
      tick();
      chk("rst_req_ready", DW'(req_ready), 1);
      chk("rst_resp_valid_after", DW'(resp_valid), 0);
   endtask

   // One transaction; abort_wait/abort_beat >= 0 reset the DUT at that point instead.
   task automatic run_txn(input logic [AW-1:0] addr, input logic wen, input logic [NB-1:0] be,
                          input logic [DW-1:0] data, input int stall_beat, input int stall_len,
                          input bit rand_stall, input bit hold_req, input int abort_wait,
                          input int abort_beat);
      logic [DW-1:0] exp_q [$];
      int unsigned   idx;
      int unsigned   base;
      int            lat;
      int            stalls;
      logic [DW-1:0] last_exp;

      req_valid   = 1'b1;
      req_address = addr;
      req_wen     = wen;
      req_be      = be;
      req_data    = data;
      chk("req_ready_idle", DW'(req_ready), 1);
      tick();
      if (!hold_req) req_valid = 1'b0;

      idx = (addr >> 2) % DEPTH;
      lat = 0;
      while (resp_valid !== 1'b1 && lat < int'(DELAY) + 16) begin
         chk("req_ready_busy", DW'(req_ready), 0);
         if (lat == abort_wait) begin
            req_valid = 1'b0;
            pulse_reset();
            return;
         end
         tick();
         lat++;
      end
      chk("latency", DW'(lat), DW'(DELAY));

      if (wen) begin
         for (int b = 0; b < int'(NB); b++) begin
            if (be[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
         end
         exp_q.push_back('0);
      end else begin
         base = idx - (idx % BL);
         for (int k = 0; k < int'(BL); k++) exp_q.push_back(ref_mem[base + k]);
      end

      foreach (exp_q[k]) begin
         last_exp = (k == exp_q.size() - 1) ? DW'(1) : DW'(0);
         chk("beat_valid", DW'(resp_valid), 1);
         chk("beat_data", resp_data, exp_q[k]);
         chk("beat_last", DW'(resp_last), last_exp);
         if (k == abort_beat) begin
            req_valid = 1'b0;
            pulse_reset();
            return;
         end
         stalls = (k == stall_beat) ? stall_len : (rand_stall ? int'($urandom_range(0, 2)) : 0);
         for (int s = 0; s < stalls; s++) begin
            resp_ready = 1'b0;
            tick();
            chk("stall_valid", DW'(resp_valid), 1);
            chk("stall_data", resp_data, exp_q[k]);
            chk("stall_last", DW'(resp_last), last_exp);
         end
         resp_ready = 1'b1;
         tick();
      end
      resp_ready = 1'b0;
      chk("done_resp_valid", DW'(resp_valid), 0);
      chk("done_req_ready", DW'(req_ready), 1);
   endtask

   initial begin
      logic [AW-1:0] ra;
      for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = DW'(i + 1);

      #1;
      chk("reset_resp_valid", DW'(resp_valid), 0);
      chk("reset_resp_last", DW'(resp_last), 0);
      chk("reset_resp_data", resp_data, 0);
      #10;
      rst_n = 1'b1;
      tick();
      chk("reset_req_ready", DW'(req_ready), 1);

      // Aligned read.
      run_txn(32'h10, 1'b0, '0, '0, -1, 0, 1'b0, 1'b0, -1, -1);
      // Reset during beat 2, then the burst must restart cleanly.
      run_txn(32'h00, 1'b0, '0, '0, -1, 0, 1'b0, 1'b0, -1, 1);
      run_txn(32'h00, 1'b0, '0, '0, -1, 0, 1'b0, 1'b0, -1, -1);
      // Backpressure on beat 2.
      run_txn(32'h00, 1'b0, '0, '0, 1, 3, 1'b0, 1'b0, -1, -1);
      // Busy rejection: request held through the burst, accepted right after.
      run_txn(32'h20, 1'b0, '0, '0, -1, 0, 1'b0, 1'b1, -1, -1);
      run_txn(32'h20, 1'b0, '0, '0, -1, 0, 1'b0, 1'b0, -1, -1);
      // Address wrap beyond DEPTH.
      run_txn(32'd4 * (32'd1024 + 32'd4), 1'b0, '0, '0, -1, 0, 1'b0, 1'b0, -1, -1);
      // Byte-enable write then readback.
      run_txn(32'h08, 1'b1, 4'b0011, 32'hAABBCCDD, -1, 0, 1'b0, 1'b0, -1, -1);
      run_txn(32'h00, 1'b0, '0, '0, -1, 0, 1'b0, 1'b0, -1, -1);
      // Write abandoned by reset before commit must leave memory unchanged.
      run_txn(32'h04, 1'b1, 4'b1111, 32'hFFFFFFFF, -1, 0, 1'b0, 1'b0, int'(DELAY) - 1, -1);
      run_txn(32'h00, 1'b0, '0, '0, -1, 0, 1'b0, 1'b0, -1, -1);

      for (int n = 0; n < 60; n++) begin
         ra = AW'(($urandom_range(0, 7) << 12) | ($urandom_range(0, 63) << 2) | $urandom_range(0, 3));
         run_txn(ra, ($urandom_range(0, 2) == 0), NB'($urandom), $urandom, -1, 0, 1'b1, 1'b0, -1, -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish expected finish before 500000ns");
      $fatal(1, "watchdog expired");
   end

endmodule
